// File: rtl/decoder_mem_responder.sv
// Banked 64-bit row store answering decoder LSU requests one cycle after accept.
// Word-interleaved banks (addr[1:0]); zero-filled after reset or on clear.
//
// state | meaning
// CLEAR | zero-filling row clr_row of every bank, requests blocked
// IDLE  | accepting one request per cycle
module decoder_mem_responder #(
  parameter int ADDR_W         = 32,
  parameter int NUM_BANKS      = 4,
  parameter int ROW_AW         = 13,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clear_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_cmd_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [7:0]        req_wmask_i,
  input  logic [63:0]       req_data_i,
  output logic              rsp_valid_o,
  output logic [63:0]       rsp_data_o,
  output logic              rsp_err_o,
  output logic              busy_o
);

  localparam int BANK_W = 2;
  localparam int ROWS   = 2 ** ROW_AW;

  typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

  state_t              state;
  logic [ROW_AW-1:0]   clr_row;
  logic [BANK_W-1:0]   bank;
  logic [ROW_AW-1:0]   row;
  logic                in_range;
  logic                accept;
  logic                acc_ok;
  logic                rsp_rd;
  logic [63:0]         rd_q;
  logic [63:0]         mem [NUM_BANKS][ROWS];

  assign bank     = req_addr_i[BANK_W-1:0];
  assign row      = req_addr_i[ROW_AW+1:2];
  assign in_range = ~|req_addr_i[ADDR_W-1:ROW_AW+2];
  assign accept   = req_valid_i & req_ready_o;
  assign acc_ok   = accept & in_range;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
      clr_row     <= '0;
      req_ready_o <= 1'b0;
      busy_o      <= CLEAR_ON_RESET;
      rsp_valid_o <= 1'b0;
      rsp_err_o   <= 1'b0;
      rsp_rd      <= 1'b0;
    end else begin
      rsp_valid_o <= accept;
      rsp_err_o   <= accept & ~in_range;
      rsp_rd      <= acc_ok & req_cmd_i;
      case (state)
        ST_CLEAR: begin
          if (clear_i) begin
            clr_row <= '0;
          end else if (&clr_row) begin
            state       <= ST_IDLE;
            clr_row     <= '0;
            req_ready_o <= 1'b1;
            busy_o      <= 1'b0;
          end else begin
            clr_row <= clr_row + 1'b1;
          end
        end
        ST_IDLE: begin
          // a request accepted on this same edge still completes before clearing
          if (clear_i) begin
            state       <= ST_CLEAR;
            clr_row     <= '0;
            req_ready_o <= 1'b0;
            busy_o      <= 1'b1;
          end else begin
            req_ready_o <= 1'b1;
            busy_o      <= 1'b0;
          end
        end
        default: begin
          state       <= ST_IDLE;
          req_ready_o <= 1'b0;
          busy_o      <= 1'b0;
        end
      endcase
    end
  end

  // Storage has no reset so it maps onto synchronous-read SRAM.
  always_ff @(posedge clk_i) begin
    if (state == ST_CLEAR) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        mem[b][clr_row] <= '0;
      end
    end else if (acc_ok && !req_cmd_i) begin
      for (int i = 0; i < 8; i++) begin
        if (req_wmask_i[i]) mem[bank][row][8*i +: 8] <= req_data_i[8*i +: 8];
      end
    end
    if (acc_ok && req_cmd_i) rd_q <= mem[bank][row];
  end

  assign rsp_data_o = rsp_rd ? rd_q : 64'd0;

endmodule
